// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: per-phase clock-enable windows and strobes for
// Fetch/Auto1/Auto2/Ind/Exec1..N, with run, halt and single-step control.
module phase_sequencer #(
    parameter  int N_EXEC            = 5,
    parameter  int SPP               = 2,
    parameter  int EXTRA_FETCH       = 1,
    parameter  int AUTO_RUN_ON_RESET = 1,
    localparam int NP                = 4 + N_EXEC,
    localparam int PW                = $clog2(4 + N_EXEC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          done,
    input  logic          halt,
    input  logic          startstop,
    input  logic          sst,
    input  logic [1:0]    seq_type,
    output logic [NP-1:0] ck,
    output logic [NP-1:0] stb,
    output logic          stb_fetch2,
    output logic [PW-1:0] phase,
    output logic          instr_end,
    output logic          running
);

    localparam int            SW         = 4;
    localparam logic [SW-1:0] SUB_LAST   = SW'(SPP - 1);
    localparam logic [SW-1:0] FETCH_LAST = SW'(SPP + EXTRA_FETCH - 1);
    localparam logic [SW-1:0] SUB_F2     = SW'(SPP);
    localparam logic [PW-1:0] PH_FETCH   = '0;
    localparam logic [PW-1:0] PH_AUTO1   = PW'(1);
    localparam logic [PW-1:0] PH_IND     = PW'(3);
    localparam logic [PW-1:0] PH_EXEC1   = PW'(4);
    localparam logic [PW-1:0] PH_EXECN   = PW'(3 + N_EXEC);

    logic [PW-1:0] phase_q, phase_d;
    logic [SW-1:0] sub_q, sub_d;
    logic          running_q, running_d;
    logic          halt_req_q, halt_req_d;
    logic          halt_prev_q, ss_prev_q, sst_prev_q;
    logic          post_rst_q;

    logic is_fetch, phase_last, end_instr;
    logic ss_edge, halt_edge, sst_edge;
    logic set_run, set_halt, clr_halt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q     <= '0;
            sub_q       <= '0;
            running_q   <= 1'b0;
            halt_req_q  <= 1'b0;
            halt_prev_q <= 1'b0;
            ss_prev_q   <= 1'b0;
            sst_prev_q  <= 1'b0;
            post_rst_q  <= (AUTO_RUN_ON_RESET != 0);
        end else begin
            phase_q     <= phase_d;
            sub_q       <= sub_d;
            running_q   <= running_d;
            halt_req_q  <= halt_req_d;
            halt_prev_q <= halt;
            ss_prev_q   <= startstop;
            sst_prev_q  <= sst;
            post_rst_q  <= 1'b0;
        end
    end

    // Phase/sub-step advance; Auto1..ExecN are consecutive indices, only Fetch branches.
    always_comb begin
        phase_d    = phase_q;
        sub_d      = sub_q;
        is_fetch   = (phase_q == PH_FETCH);
        phase_last = is_fetch ? (sub_q == FETCH_LAST) : (sub_q == SUB_LAST);
        end_instr  = running_q && !is_fetch &&
                     (done || ((phase_q == PH_EXECN) && (sub_q == SUB_LAST)));
        if (running_q) begin
            if (end_instr) begin
                phase_d = PH_FETCH;
                sub_d   = '0;
            end else if (phase_last) begin
                sub_d = '0;
                if (is_fetch) begin
                    case (seq_type)
                        2'b00:   phase_d = PH_EXEC1;
                        2'b01:   phase_d = PH_IND;
                        default: phase_d = PH_AUTO1;
                    endcase
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end else begin
                sub_d = sub_q + 1'b1;
            end
        end
    end

    // Run control: a halt request set in the same clock always beats a clear.
    always_comb begin
        ss_edge    = startstop & ~ss_prev_q;
        halt_edge  = halt & ~halt_prev_q;
        sst_edge   = sst & ~sst_prev_q;
        set_run    = (ss_edge && !running_q) || sst_edge || post_rst_q;
        set_halt   = (ss_edge && running_q) || (halt_edge && running_q) ||
                     sst_edge || post_rst_q;
        clr_halt   = ss_edge && !running_q;
        running_d  = running_q | set_run;
        halt_req_d = set_halt ? 1'b1 : (clr_halt ? 1'b0 : halt_req_q);
        if (end_instr && halt_req_d) begin
            running_d  = 1'b0;
            halt_req_d = 1'b0;
        end
    end

    always_comb begin
        ck = '0;
        stb = '0;
        for (int p = 0; p < NP; p++) begin
            ck[p]  = !reset && (phase_q == PW'(p));
            stb[p] = !reset && running_q && (phase_q == PW'(p)) && (sub_q == SUB_LAST);
        end
        stb_fetch2 = (EXTRA_FETCH != 0) && !reset && running_q && is_fetch &&
                     (sub_q == SUB_F2);
        instr_end  = !reset && end_instr;
        phase      = phase_q;
        running    = running_q;
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: vector table for whole-instruction
// sequences plus hand-written run/stop, reset-abort and alternate-config cases.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rst6 = 1'b1;
    logic       done = 1'b0, halt = 1'b0, startstop = 1'b0, sst = 1'b0;
    logic [1:0] seq_type = 2'b00;

    logic [8:0] ck, stb;
    logic       stb_fetch2, instr_end, running;
    logic [3:0] phase;

    logic [5:0] ck6, stb6;
    logic       f2_6, ie6, run6;
    logic [2:0] phase6;

    int total = 0;
    int bad = 0;
    int ie_n, run_n;

    always #5 clk = ~clk;

    phase_sequencer dut (
        .clk(clk), .reset(reset), .done(done), .halt(halt),
        .startstop(startstop), .sst(sst), .seq_type(seq_type),
        .ck(ck), .stb(stb), .stb_fetch2(stb_fetch2), .phase(phase),
        .instr_end(instr_end), .running(running)
    );

    phase_sequencer #(.N_EXEC(2), .SPP(3), .EXTRA_FETCH(0), .AUTO_RUN_ON_RESET(1)) u6 (
        .clk(clk), .reset(rst6), .done(done), .halt(halt),
        .startstop(startstop), .sst(sst), .seq_type(seq_type),
        .ck(ck6), .stb(stb6), .stb_fetch2(f2_6), .phase(phase6),
        .instr_end(ie6), .running(run6)
    );

    typedef struct {
        logic       ss, st, hl, dn;
        logic [1:0] sq;
        int         ph;
        logic [8:0] sb;
        logic       f2, ie, run;
    } vec_t;

    vec_t vq[$];

    function automatic void row(input logic ss_v, st_v, hl_v, dn_v, input logic [1:0] sq_v,
                                input int ph_v, input logic [8:0] sb_v,
                                input logic f2_v, ie_v, run_v);
        vec_t v;
        v.ss = ss_v; v.st = st_v; v.hl = hl_v; v.dn = dn_v; v.sq = sq_v;
        v.ph = ph_v; v.sb = sb_v; v.f2 = f2_v; v.ie = ie_v; v.run = run_v;
        vq.push_back(v);
    endfunction

    function automatic void fetch3(input logic ss_v, input logic [1:0] sq_v);
        row(ss_v, 0, 0, 0, sq_v, 0, 9'h000, 0, 0, 1);
        row(ss_v, 0, 0, 0, sq_v, 0, 9'h001, 0, 0, 1);
        row(ss_v, 0, 0, 0, sq_v, 0, 9'h000, 1, 0, 1);
    endfunction

    function automatic void ex2(input logic ss_v, input logic [1:0] sq_v, input int p,
                                input logic last);
        row(ss_v, 0, 0, 0, sq_v, p, 9'h000, 0, 0, 1);
        row(ss_v, 0, 0, 0, sq_v, p, 9'(1 << p), 0, last, 1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic sample();
        #1;
        if (instr_end) ie_n++;
        if (running) run_n++;
    endtask

    initial begin
        int r6, i6, f6, sc6;
        logic [5:0] sor6;

        // Test 1: seq 00, startstop run, halt request in Exec2
        row(1, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        fetch3(1, 2'b00);
        ex2(1, 2'b00, 4, 0);
        row(1, 0, 1, 0, 2'b00, 5, 9'h000, 0, 0, 1);
        row(1, 0, 0, 0, 2'b00, 5, 9'h020, 0, 0, 1);
        ex2(1, 2'b00, 6, 0); ex2(1, 2'b00, 7, 0); ex2(1, 2'b00, 8, 1);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        // Test 2: seq 01, single step through Ind
        row(0, 1, 0, 0, 2'b01, 0, 9'h000, 0, 0, 0);
        fetch3(0, 2'b01);
        for (int p = 3; p <= 8; p++) ex2(0, 2'b01, p, p == 8);
        row(0, 0, 0, 0, 2'b01, 0, 9'h000, 0, 0, 0);
        // Test 3: seq 10, single step through Auto1/Auto2/Ind
        row(0, 1, 0, 0, 2'b10, 0, 9'h000, 0, 0, 0);
        fetch3(0, 2'b10);
        for (int p = 1; p <= 8; p++) ex2(0, 2'b10, p, p == 8);
        row(0, 0, 0, 0, 2'b10, 0, 9'h000, 0, 0, 0);
        // Test 4: done ignored in Fetch, ends instruction in Exec1
        row(0, 1, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 0, 1, 2'b00, 0, 9'h000, 0, 0, 1);
        row(0, 0, 0, 1, 2'b00, 0, 9'h001, 0, 0, 1);
        row(0, 0, 0, 1, 2'b00, 0, 9'h000, 1, 0, 1);
        row(0, 0, 0, 0, 2'b00, 4, 9'h000, 0, 0, 1);
        row(0, 0, 0, 1, 2'b00, 4, 9'h010, 0, 1, 1);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        // Test 5: simultaneous startstop+sst while idle, then idle halt edge
        row(1, 1, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        fetch3(1, 2'b00);
        for (int p = 4; p <= 8; p++) ex2(1, 2'b00, p, p == 8);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 1, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);
        row(0, 0, 0, 0, 2'b00, 0, 9'h000, 0, 0, 0);

        #2;
        chk("reset_outputs", {ck, stb, stb_fetch2, instr_end, running, phase}, 0);

        // Auto-run of one instruction after reset release
        @(negedge clk);
        reset = 1'b0;
        ie_n = 0; run_n = 0;
        repeat (20) begin @(negedge clk); sample(); end
        chk("autorun_clocks", run_n, 13);
        chk("autorun_instr_end", ie_n, 1);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            startstop = vq[i].ss; sst = vq[i].st; halt = vq[i].hl;
            done = vq[i].dn; seq_type = vq[i].sq;
            #1;
            chk($sformatf("row%0d", i), {ck, stb, stb_fetch2, instr_end, running, phase},
                {9'(1 << vq[i].ph), vq[i].sb, vq[i].f2, vq[i].ie, vq[i].run, 4'(vq[i].ph)});
        end

        // Continuous run: startstop to start, second startstop mid-instruction 2
        seq_type = 2'b00; halt = 1'b0; done = 1'b0; sst = 1'b0;
        ie_n = 0; run_n = 0;
        @(negedge clk); startstop = 1'b1; sample();
        @(negedge clk); startstop = 1'b0; sample();
        repeat (16) begin @(negedge clk); sample(); end
        @(negedge clk); startstop = 1'b1; sample();
        @(negedge clk); startstop = 1'b0; sample();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); sample();
            if (!running) break;
        end
        chk("cont_stopped", running, 0);
        chk("cont_instr_end", ie_n, 2);
        chk("cont_clocks", run_n, 26);
        chk("cont_phase", phase, 0);

        // Reset asserted at Exec3 sub-step 0 aborts immediately
        @(negedge clk); sst = 1'b1;
        @(negedge clk); sst = 1'b0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (phase == 4'd6) break;
            @(negedge clk); #1;
        end
        chk("reach_exec3", phase, 6);
        #1 reset = 1'b1;
        #1 chk("reset_mid_instr", {ck, stb, stb_fetch2, instr_end, running, phase}, 0);
        @(negedge clk);
        chk("reset_held", {ck, stb, stb_fetch2, instr_end, running, phase}, 0);
        reset = 1'b0;
        ie_n = 0; run_n = 0;
        repeat (20) begin @(negedge clk); sample(); end
        chk("rerun_clocks", run_n, 13);
        chk("rerun_instr_end", ie_n, 1);

        // Alternate configuration: SPP=3, no extra fetch, two exec phases
        chk("u6_reset", {ck6, stb6, f2_6, ie6, run6, phase6}, 0);
        @(negedge clk); rst6 = 1'b0;
        r6 = 0; i6 = 0; f6 = 0; sc6 = 0; sor6 = '0;
        repeat (20) begin
            @(negedge clk); #1;
            if (run6) r6++;
            if (ie6) i6++;
            if (f2_6) f6++;
            sor6 |= stb6;
            sc6 += $countones(stb6);
        end
        chk("u6_clocks", r6, 9);
        chk("u6_instr_end", i6, 1);
        chk("u6_fetch2", f6, 0);
        chk("u6_stb_bits", sor6, 6'b110001);
        chk("u6_stb_count", sc6, 3);
        chk("u6_idle_phase", phase6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the fixed 5-execute-phase instruction sequencer. It generates per-phase clock-enable windows (ck) and single-cycle strobes (stb) for Fetch, Auto1, Auto2, Ind and N execute phases. Phase length, execute-phase count and the extra fetch strobe are configurable. It owns run/halt/single-step control and sits between the front-panel debounce logic and the instruction-decode/datapath blocks. It adds an instruction-boundary halt, an explicit phase index output and an end-of-instruction pulse.

Parameters:
N_EXEC, 5, number of execute phases (1..12)
SPP, 2, clocks per phase (2..8); the strobe fires on the last clock of the phase
EXTRA_FETCH, 1, 0/1; 1 lengthens Fetch by one clock and enables stb_fetch2
AUTO_RUN_ON_RESET, 1, 1 runs exactly one instruction after reset deasserts

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
done  in  1  level; ends the current instruction early (ignored during Fetch)
halt  in  1  rising edge requests a halt at the next instruction boundary
startstop  in  1  rising edge toggles continuous run
sst  in  1  rising edge runs exactly one instruction
seq_type  in  2  {isPPIND,isIND}, sampled on the last Fetch clock
ck  out  4+N_EXEC  phase window; bit 0 Fetch, 1 Auto1, 2 Auto2, 3 Ind, 4+k Exec(k+1)
stb  out  4+N_EXEC  one-clock strobe on the last clock of each phase, same bit map (bit 0 = stbFetch)
stb_fetch2  out  1  strobe on the extra Fetch clock; constant 0 when EXTRA_FETCH=0
phase  out  clog2(4+N_EXEC)  current phase index
instr_end  out  1  one-clock pulse on the clock the sequence returns to Fetch sub-step 0
running  out  1  run flag

Behaviour:
- State: phase index, sub-step counter, running, halt_req, edge-detect registers for halt/startstop/sst, and a post-reset flag.
- On reset (asynchronous), all state clears: phase=0, sub-step=0, running=0, halt_req=0. The edge registers clear to 0. All ck/stb outputs are forced to 0 while reset is high.
- Fetch lasts SPP+EXTRA_FETCH clocks. stb[0] fires at sub-step SPP-1. stb_fetch2 fires at sub-step SPP (EXTRA_FETCH=1 only).
- Every other phase lasts SPP clocks; stb[p] fires at sub-step SPP-1.
- ck[p] is high for every clock of phase p, including while idle at Fetch sub-step 0.
- The counter advances only while running=1. When idle it holds its value (normally Fetch sub-step 0).
- Next phase after Fetch, decided by seq_type on the last Fetch clock:
  - 00 -> Exec1
  - 01 -> Ind
  - 10 or 11 -> Auto1
  - Auto1 -> Auto2 -> Ind -> Exec1 -> ... -> ExecN.
- Instruction end:
  - If done=1 on any clock outside Fetch, or at the last clock of ExecN, the next state is Fetch sub-step 0.
  - instr_end pulses on that same transition clock.
  - done has priority over the normal advance.
- Run control, evaluated on rising edges detected against the previous-clock input values:
  - startstop while idle: running<=1, halt_req<=0.
  - startstop while running: halt_req<=1.
  - halt while running: halt_req<=1. A halt edge while idle is ignored.
  - sst: running<=1, halt_req<=1.
  - Simultaneous edges: any set of halt_req wins over a clear.
- Boundary halt: on the instruction-end transition, if halt_req=1 (including a request that arrives that same clock), then running<=0 and halt_req<=0. The counter still lands on Fetch sub-step 0. The machine never stops mid-instruction.
- Post-reset: if AUTO_RUN_ON_RESET=1, the first clock after reset deasserts sets running=1 and halt_req=1, so one instruction executes.
- Reset asserted mid-instruction aborts immediately. No strobe or instr_end is emitted.

Test Plan:
1. Defaults, seq_type=00, startstop pulse then a halt pulse in Exec2: Fetch runs 3 clocks (stb[0] at clock 1, stb_fetch2 at clock 2), then Exec1..Exec5 at 2 clocks each. The instruction is 13 clocks with instr_end at clock 13. running drops at that boundary and phase=0.
2. seq_type=01 with sst: Fetch, Ind, Exec1..5 runs for 15 clocks, stb[3] fires once, then the block idles at phase 0 with running=0.
3. seq_type=10 with sst: Fetch, Auto1, Auto2, Ind, Exec1..5 runs for 19 clocks, with strobe order stb0, fetch2, stb1, stb2, stb3, stb4..stb8.
4. done=1 during the Exec1 strobe clock: the next clock is Fetch sub-step 0 and instr_end pulses. A total of 5 clocks from Fetch start. done held during Fetch has no effect.
5. Simultaneous startstop and sst edges while idle: exactly one instruction runs and running returns to 0. Halt edge while idle: no change.
6. Reset asserted at Exec3 sub-step 0: all outputs go to 0 asynchronously. After release with AUTO_RUN_ON_RESET=1, exactly one instruction runs. With SPP=3, EXTRA_FETCH=0, N_EXEC=2 and seq_type=00, that instruction is 3+6=9 clocks and stb_fetch2 stays 0.
